// File: rtl/mux_pkg.sv
// Shared types and helpers for the arb_muxn arbiter/mux and its picker.
// Build option ARB_MUXN_FIXED_PRIO_EN (used by arb_muxn) swaps round-robin for fixed priority.
package mux_pkg;

   localparam int MAX_N = 16;
   localparam int IDXW  = $clog2(MAX_N);

   typedef enum logic {
      MODE_RR,
      MODE_FORCE
   } arb_mode_t;

   typedef enum logic {
      ST_EMPTY,
      ST_FULL
   } out_state_t;

   // Converts a one-hot (or zero) vector to the index of its set bit; zero maps to 0.
   function automatic logic [IDXW-1:0] onehot_to_idx(input logic [MAX_N-1:0] oh);
      logic [IDXW-1:0] idx;
      idx = '0;
      for (int i = 0; i < MAX_N; i++) begin
         if (oh[i]) begin
            idx = idx | IDXW'(i);
         end
      end
      return idx;
   endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: finds the first requester after ptr, wrapping modulo N.
// Uses a doubled request vector so the wrap becomes a plain lowest-index search over a window.
module rr_picker
   import mux_pkg::*;
#(
   parameter int N    = 6,
   parameter int SELW = $clog2(N)
) (
   input  logic [N-1:0]    req,
   input  logic [SELW-1:0] ptr,
   output logic            gnt_vld,
   output logic [SELW-1:0] gnt_idx
);

   logic [2*N-1:0] req_dbl;
   logic [N-1:0]   gnt_oh;
   int             ptr_i;

   assign req_dbl = {req, req};
   assign ptr_i   = int'(ptr);

   // Search positions ptr+1 .. ptr+N of the doubled vector, lowest position wins.
   always_comb begin
      gnt_oh  = '0;
      gnt_vld = 1'b0;
      for (int j = 0; j < 2*N; j++) begin
         if (!gnt_vld && (j > ptr_i) && (j <= ptr_i + N) && req_dbl[j]) begin
            gnt_vld       = 1'b1;
            gnt_oh[j % N] = 1'b1;
         end
      end
   end

   assign gnt_idx = SELW'(onehot_to_idx(MAX_N'(gnt_oh)));

endmodule

// File: rtl/arb_muxn.sv
// N-channel valid/ready arbiter-mux with a single registered output beat.
// Round-robin arbitration by default, or forced steering via force_en/force_sel.
// Define ARB_MUXN_FIXED_PRIO_EN to replace round-robin with lowest-index-wins priority.
module arb_muxn
   import mux_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int N     = 6,
   parameter int SELW  = $clog2(N)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [N*WIDTH-1:0]   in_data,
   input  logic [N-1:0]         in_valid,
   output logic [N-1:0]         in_ready,
   input  logic                 force_en,
   input  logic [SELW-1:0]      force_sel,
   output logic [WIDTH-1:0]     out_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [SELW-1:0]      out_sel
);

   out_state_t       state_q, state_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic [SELW-1:0]  sel_q, sel_d;
   logic [SELW-1:0]  pick_ptr;
   logic             pick_vld;
   logic [SELW-1:0]  pick_idx;
   logic             load_ok;
   arb_mode_t        mode;
   logic             force_hit;
   logic             grant_vld;
   logic [SELW-1:0]  grant_idx;
   logic [WIDTH-1:0] grant_data;

`ifdef ARB_MUXN_FIXED_PRIO_EN
   assign pick_ptr = SELW'(N - 1);
`else
   logic [SELW-1:0]  rr_ptr_q, rr_ptr_d;
   assign pick_ptr = rr_ptr_q;
`endif

   rr_picker #(
      .N    (N),
      .SELW (SELW)
   ) u_picker (
      .req     (in_valid),
      .ptr     (pick_ptr),
      .gnt_vld (pick_vld),
      .gnt_idx (pick_idx)
   );

   assign load_ok = (state_q == ST_EMPTY) || out_ready;
   assign mode    = force_en ? MODE_FORCE : MODE_RR;

   // Forced path only hits for an in-range index whose channel is valid.
   always_comb begin
      force_hit = 1'b0;
      for (int i = 0; i < N; i++) begin
         if ((force_sel == SELW'(i)) && in_valid[i]) begin
            force_hit = 1'b1;
         end
      end
   end

   // Final grant: nothing while the output register cannot accept a beat.
   always_comb begin
      grant_vld = 1'b0;
      grant_idx = '0;
      if (load_ok) begin
         if (mode == MODE_FORCE) begin
            grant_vld = force_hit;
            grant_idx = force_sel;
         end else begin
            grant_vld = pick_vld;
            grant_idx = pick_idx;
         end
      end
   end

   // One-hot ready back to the granted source, suppressed while in reset.
   always_comb begin
      in_ready   = '0;
      grant_data = '0;
      for (int i = 0; i < N; i++) begin
         if (grant_idx == SELW'(i)) begin
            in_ready[i] = rst_n && grant_vld;
            grant_data  = in_data[i*WIDTH +: WIDTH];
         end
      end
   end

   // Output register state update: load on grant, drain on consumer accept, else hold.
   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      sel_d   = sel_q;
      if (grant_vld) begin
         state_d = ST_FULL;
         data_d  = grant_data;
         sel_d   = grant_idx;
      end else if (out_ready) begin
         state_d = ST_EMPTY;
      end
   end

`ifndef ARB_MUXN_FIXED_PRIO_EN
   // Round-robin pointer follows round-robin grants only; forced beats leave it alone.
   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (grant_vld && (mode == MODE_RR)) begin
         rr_ptr_d = grant_idx;
      end
   end
`endif

   // State register with synchronous active-low reset; pointer resets so channel 0 goes first.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= ST_EMPTY;
         data_q   <= '0;
         sel_q    <= '0;
`ifndef ARB_MUXN_FIXED_PRIO_EN
         rr_ptr_q <= SELW'(N - 1);
`endif
      end else begin
         state_q  <= state_d;
         data_q   <= data_d;
         sel_q    <= sel_d;
`ifndef ARB_MUXN_FIXED_PRIO_EN
         rr_ptr_q <= rr_ptr_d;
`endif
      end
   end

   // Registered outputs straight from state.
   always_comb begin
      out_valid = (state_q == ST_FULL);
      out_data  = data_q;
      out_sel   = sel_q;
   end

endmodule

// File: tb/tb_arb_muxn.sv
// Directed self-checking bench for arb_muxn (default round-robin build, N=6, WIDTH=32).
module tb_arb_muxn;

   localparam int WIDTH = 32;
   localparam int N     = 6;
   localparam int SELW  = 3;

   logic               clk = 1'b0;
   logic               rst_n;
   logic [N*WIDTH-1:0] in_data;
   logic [N-1:0]       in_valid;
   logic [N-1:0]       in_ready;
   logic               force_en;
   logic [SELW-1:0]    force_sel;
   logic [WIDTH-1:0]   out_data;
   logic               out_valid;
   logic               out_ready;
   logic [SELW-1:0]    out_sel;

   int vectors     = 0;
   int miscompares = 0;

   // Free-running clock.
   always #5 clk = ~clk;

   arb_muxn #(
      .WIDTH (WIDTH),
      .N     (N)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .force_en  (force_en),
      .force_sel (force_sel),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sel   (out_sel)
   );

   function automatic logic [31:0] chanData(input int i);
      return 32'hC0DE_0000 + 32'(i) * 32'h111;
   endfunction

   function automatic logic [31:0] oneHot(input int i);
      return 32'(1) << i;
   endfunction

   task automatic applyStimulus(input logic rstn, input logic [N-1:0] v, input logic ordy,
                                input logic fen, input logic [SELW-1:0] fsel);
      rst_n     = rstn;
      in_valid  = v;
      out_ready = ordy;
      force_en  = fen;
      force_sel = fsel;
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic checkBeat(input string tag, input logic v, input int sel, input logic [31:0] data);
      checkOutput({tag, "_valid"}, 32'(out_valid), 32'(v));
      checkOutput({tag, "_sel"},   32'(out_sel),   32'(sel));
      checkOutput({tag, "_data"},  out_data,       data);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Directed sequence; each expected value is worked out by hand from the arbitration rules.
   initial begin
      int exp_g[3];
      exp_g = '{2, 5, 2};
      for (int i = 0; i < N; i++) in_data[i*WIDTH +: WIDTH] = chanData(i);

      // Reset with all channels requesting: no ready, cleared outputs.
      applyStimulus(1'b0, 6'b111111, 1'b1, 1'b0, 3'd0);
      checkOutput("reset_ready", 32'(in_ready), 32'd0);
      tick();
      tick();
      checkOutput("reset_ready2", 32'(in_ready), 32'd0);
      checkBeat("reset", 1'b0, 0, 32'd0);

      // All valid, consumer always ready: 0..5 twice, leaving the pointer at 5.
      applyStimulus(1'b1, 6'b111111, 1'b1, 1'b0, 3'd0);
      for (int k = 0; k < 12; k++) begin
         checkOutput("rr_ready", 32'(in_ready), oneHot(k % 6));
         tick();
         checkBeat("rr", 1'b1, k % 6, chanData(k % 6));
      end

      // Sparse requests 2 and 5 from pointer 5: 2, 5, 2.
      applyStimulus(1'b1, 6'b100100, 1'b1, 1'b0, 3'd0);
      for (int k = 0; k < 3; k++) begin
         checkOutput("sparse_ready", 32'(in_ready), oneHot(exp_g[k]));
         tick();
         checkBeat("sparse", 1'b1, exp_g[k], chanData(exp_g[k]));
      end

      // Stall for three cycles holding channel 2's beat.
      applyStimulus(1'b1, 6'b111111, 1'b0, 1'b0, 3'd0);
      for (int k = 0; k < 3; k++) begin
         checkOutput("stall_ready", 32'(in_ready), 32'd0);
         tick();
         checkBeat("stall", 1'b1, 2, chanData(2));
      end
      applyStimulus(1'b1, 6'b111111, 1'b1, 1'b0, 3'd0);
      checkOutput("release_ready", 32'(in_ready), oneHot(3));
      tick();
      checkBeat("release", 1'b1, 3, chanData(3));
      checkOutput("release2_ready", 32'(in_ready), oneHot(4));
      tick();
      checkBeat("release2", 1'b1, 4, chanData(4));

      // Forced channel 3 not valid: no grant, beat drains, data/sel hold.
      applyStimulus(1'b1, 6'b110111, 1'b1, 1'b1, 3'd3);
      checkOutput("force_miss_ready", 32'(in_ready), 32'd0);
      tick();
      checkBeat("force_drain", 1'b0, 4, chanData(4));
      applyStimulus(1'b1, 6'b111111, 1'b1, 1'b1, 3'd3);
      checkOutput("force_hit_ready", 32'(in_ready), oneHot(3));
      tick();
      checkBeat("force_hit", 1'b1, 3, chanData(3));
      // Pointer stayed at 4, so round-robin resumes at 5.
      applyStimulus(1'b1, 6'b111111, 1'b1, 1'b0, 3'd0);
      checkOutput("after_force_ready", 32'(in_ready), oneHot(5));
      tick();
      checkBeat("after_force", 1'b1, 5, chanData(5));

      // Out-of-range force index never grants.
      applyStimulus(1'b1, 6'b111111, 1'b1, 1'b1, 3'd7);
      for (int k = 0; k < 3; k++) begin
         checkOutput("force_oor_ready", 32'(in_ready), 32'd0);
         tick();
         checkBeat("force_oor", 1'b0, 5, chanData(5));
      end

      // Two beats (0, 1), then reset while stalled with a beat pending.
      applyStimulus(1'b1, 6'b111111, 1'b1, 1'b0, 3'd0);
      checkOutput("pre_rst_ready0", 32'(in_ready), oneHot(0));
      tick();
      checkBeat("pre_rst0", 1'b1, 0, chanData(0));
      checkOutput("pre_rst_ready1", 32'(in_ready), oneHot(1));
      tick();
      checkBeat("pre_rst1", 1'b1, 1, chanData(1));
      applyStimulus(1'b0, 6'b111111, 1'b0, 1'b0, 3'd0);
      checkOutput("mid_rst_ready", 32'(in_ready), 32'd0);
      tick();
      checkBeat("mid_rst", 1'b0, 0, 32'd0);
      applyStimulus(1'b1, 6'b111111, 1'b1, 1'b0, 3'd0);
      checkOutput("post_rst_ready", 32'(in_ready), oneHot(0));
      tick();
      checkBeat("post_rst", 1'b1, 0, chanData(0));

      // Requests 4 and 5 from pointer 0: round-robin gives 4 then 5.
      applyStimulus(1'b1, 6'b110000, 1'b1, 1'b0, 3'd0);
      checkOutput("hi_ready0", 32'(in_ready), oneHot(4));
      tick();
      checkBeat("hi0", 1'b1, 4, chanData(4));
      checkOutput("hi_ready1", 32'(in_ready), oneHot(5));
      tick();
      checkBeat("hi1", 1'b1, 5, chanData(5));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
